// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative mult/multu/div/divu engine in the EX stage; freezes the front end while iterating.
// Define MULDIV_FAST_MUL_EN to compute mult/multu with a single-cycle multiplier instead of 32 shift-add steps.
module ex_muldiv_unit #(
    parameter int unsigned ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    input  logic        stall_ex,
    output logic        busy,
    output logic        stallreq,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [2*W-1:0]   acc;
    logic [2*W-1:0]   mcand;
    logic [W-1:0]     opb;
    logic             sign_a;
    logic             sign_b;

    logic             idle_or_done;
    logic             a_neg;
    logic             b_neg;
    logic [W-1:0]     abs_a;
    logic [W-1:0]     abs_b;
    logic [2*W-1:0]   mul_nxt;
    logic [2*W-1:0]   prod_fix;
    logic [W:0]       div_shift;
    logic [W:0]       div_diff;
    logic [2*W-1:0]   div_nxt;
    logic [W-1:0]     quo_fix;
    logic [W-1:0]     rem_fix;
    logic [2*W-1:0]   fast_prod;
    logic             fast_mul;

`ifdef MULDIV_FAST_MUL_EN
    // Sign-extend to 64 bits; the low 64 bits of the product are then correct for both signednesses.
    logic [2*W-1:0] fast_a;
    logic [2*W-1:0] fast_b;
    assign fast_a    = {{W{!op[0] && src_a[W-1]}}, src_a};
    assign fast_b    = {{W{!op[0] && src_b[W-1]}}, src_b};
    assign fast_prod = fast_a * fast_b;
    assign fast_mul  = 1'b1;
`else
    assign fast_prod = '0;
    assign fast_mul  = 1'b0;
`endif

    // Operand conditioning and one iteration of each datapath, plus the sign fix-up of the final step.
    always_comb begin
        idle_or_done = (state == IDLE) || (state == DONE);
        a_neg        = !op[0] && src_a[W-1];
        b_neg        = !op[0] && src_b[W-1];
        abs_a        = a_neg ? -src_a : src_a;
        abs_b        = b_neg ? -src_b : src_b;

        mul_nxt      = acc + (opb[0] ? mcand : '0);
        prod_fix     = (sign_a ^ sign_b) ? -mul_nxt : mul_nxt;

        // 33-bit trial subtract: bit W set means the divisor did not fit.
        div_shift    = {acc[2*W-1:W], acc[W-1]};
        div_diff     = div_shift - {1'b0, opb};
        div_nxt      = {(div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0]),
                        acc[W-2:0], !div_diff[W]};
        quo_fix      = (sign_a ^ sign_b) ? -div_nxt[W-1:0] : div_nxt[W-1:0];
        rem_fix      = sign_a ? -div_nxt[2*W-1:W] : div_nxt[2*W-1:W];
    end

    assign stallreq = (start && idle_or_done && !cancel) || busy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            counter <= '0;
            acc     <= '0;
            mcand   <= '0;
            opb     <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
        end else if (cancel) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                MUL: begin
                    acc     <= mul_nxt;
                    mcand   <= {mcand[2*W-2:0], 1'b0};
                    opb     <= {1'b0, opb[W-1:1]};
                    counter <= counter + CNT_W'(1);
                    if (counter == LAST) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        {hi, lo} <= prod_fix;
                    end
                end
                DIV: begin
                    acc     <= div_nxt;
                    counter <= counter + CNT_W'(1);
                    if (counter == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= rem_fix;
                        lo    <= quo_fix;
                    end
                end
                default: begin
                    if (state == DONE && stall_ex) begin
                        done <= 1'b1;
                    end else if (start) begin
                        sign_a  <= a_neg;
                        sign_b  <= b_neg;
                        counter <= '0;
                        if (op[1] && src_b == '0) begin
                            // Divide by zero bypasses iteration entirely.
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            hi    <= src_a;
                            lo    <= '1;
                        end else if (op[1]) begin
                            state <= DIV;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            acc   <= {W'(0), abs_a};
                            opb   <= abs_b;
                        end else if (fast_mul) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            {hi, lo} <= fast_prod;
                        end else begin
                            state <= MUL;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            acc   <= '0;
                            mcand <= {W'(0), abs_a};
                            opb   <= abs_b;
                        end
                    end else begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed vectors for ex_muldiv_unit; expected HI/LO and completion cycle are
// queued at issue and checked by an independent monitor whenever a new result appears.
module tb_ex_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        stall_ex;
    logic        busy;
    logic        stallreq;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    ex_muldiv_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .cancel   (cancel),
        .stall_ex (stall_ex),
        .busy     (busy),
        .stallreq (stallreq),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: a new result is a rising done, or done following an accepted back-to-back issue.
    logic prev_done  = 1'b0;
    logic prev_hold  = 1'b0;
    logic prev_issue = 1'b0;
    always @(negedge clk) begin
        if (rst && done) begin
            if (!prev_done || prev_issue) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", {hi, lo}, 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    last_exp = sb.pop_front();
                    check("result", {hi, lo}, {last_exp.hi, last_exp.lo});
                    check("latency", 64'(cyc), 64'(last_exp.due));
                end
            end else if (prev_hold) begin
                check("hold_result", {hi, lo}, {last_exp.hi, last_exp.lo});
            end
        end
        prev_done  = rst && done;
        prev_hold  = rst && done && stall_ex && !cancel;
        prev_issue = rst && start && !cancel && !busy && !(done && stall_ex);
    end

    // Drive one op in the current cycle; queue its expectation unless it is going to be aborted.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int lat,
                         input bit push);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        if (push) sb.push_back('{hi: ehi, lo: elo, due: cyc + lat});
        #2;
        check("stallreq_issue", 64'(stallreq), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) check("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sr_bad;
        rst = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        cancel = 1'b0; stall_ex = 1'b0;
        step(2);
        check("reset_outputs", 64'({busy, done, stallreq, hi, lo}), 64'd0);
        rst = 1'b1;
        step(1);

        // multu max x max, with stallreq held through every iteration cycle
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT, 1'b1);
        sr_bad = 0;
        for (int i = 1; i < MUL_LAT; i++) begin
            if (!stallreq) sr_bad++;
            @(posedge clk); #1;
        end
        check("stallreq_iter", 64'(sr_bad), 64'd0);
        check("done_at_latency", 64'(done), 64'd1);
        check("stallreq_in_done", 64'(stallreq), 64'd0);
        step(1);
        check("idle_after_done", 64'({busy, done}), 64'd0);
        check("hi_lo_kept_idle", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        issue(2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT, 1'b1);
        wait_done(40); step(1);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT, 1'b1);
        wait_done(40); step(1);
        issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT, 1'b1);
        wait_done(40); step(1);

        // divide by zero and the signed overflow case
        issue(2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1, 1'b1);
        wait_done(40); step(1);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_LAT, 1'b1);
        wait_done(40); step(1);

        // cancel mid-divide: no result, hi/lo keep the previous op's values
        issue(2'b10, 32'd1000, 32'd3, 32'd0, 32'd0, DIV_LAT, 1'b0);
        step(10);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        check("cancel_flags", 64'({busy, done, stallreq}), 64'd0);
        check("cancel_hi_lo", {hi, lo}, 64'h0000_0000_8000_0000);
        step(40);
        check("cancel_hi_lo_later", {hi, lo}, 64'h0000_0000_8000_0000);

        // cancel and start together: cancel wins
        op = 2'b11; src_a = 32'd9; src_b = 32'd3; start = 1'b1; cancel = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        check("cancel_beats_start", 64'({busy, done}), 64'd0);

        // reset mid-divide clears everything
        issue(2'b10, 32'd1000, 32'd3, 32'd0, 32'd0, DIV_LAT, 1'b0);
        step(5);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_mid_op", 64'({busy, done, stallreq, hi, lo}), 64'd0);
        rst = 1'b1;
        step(40);
        check("reset_no_done", 64'({done, hi, lo}), 64'd0);

        // stall in DONE for 3 cycles, then back-to-back issue in the release cycle
        issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT, 1'b1);
        wait_done(40);
        stall_ex = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall_done_held", 64'({done, hi, lo}), {1'b1, 32'd2, 32'd14});
        end
        stall_ex = 1'b0;
        issue(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, MUL_LAT, 1'b1);
        wait_done(40); step(1);

        // start while iterating is ignored
        issue(2'b00, 32'd7, 32'd9, 32'd0, 32'd63, MUL_LAT, 1'b1);
        if (MUL_LAT > 1) begin
            step(5);
            op = 2'b00; src_a = 32'd3; src_b = 32'd3; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        wait_done(40); step(1);

        begin
            int n = 0;
            while (sb.size() != 0 && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative multiply/divide engine in the EX stage, directly downstream of ID. It consumes the decoded mult/multu/div/divu operands that ID places on the ID-to-EX bus. It produces 64-bit HI/LO results and holds the pipeline through the stall request while it iterates. HI/LO results go on to the EX-to-ID/MEM forwarding paths.

Parameters:
ITER, 32, number of shift/subtract iterations; fixed at 32 for 32-bit operands.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low (asserted when rst==0)
start  in  1  op request; sampled only in IDLE or DONE
op  in  2  00 mult, 01 multu, 10 div, 11 divu
src_a  in  32  rs value (multiplicand / dividend)
src_b  in  32  rt value (multiplier / divisor)
cancel  in  1  flush; abort any in-flight op
stall_ex  in  1  EX stage held by a later stage; results must be held
busy  out  1  engine iterating (state MUL or DIV)
stallreq  out  1  request to freeze IF/ID/EX
done  out  1  hi/lo valid for the current op
hi  out  32  HI result (high product / remainder)
lo  out  32  LO result (low product / quotient)

Behaviour:
- States: IDLE, MUL, DIV, DONE.
- Reset (rst==0 at clock edge): state=IDLE, busy=0, done=0, stallreq=0, hi=0, lo=0, counter=0, internal registers=0. Reset overrides every other input.
- IDLE/DONE + start=1:
  - Latch |src_a|, |src_b| (signed ops only) and the sign flags.
  - counter=0; next state MUL (op[1]=0) or DIV (op[1]=1).
- stallreq = (start & (IDLE|DONE) & ~cancel) | busy. Combinational; high in the issue cycle, so ID/EX freeze immediately.
- MUL: radix-2 shift-add, one multiplier bit per cycle, 64-bit accumulator.
- DIV: restoring division, one quotient bit per cycle; 33-bit trial subtract of the partial remainder minus the divisor.
- counter increments each iteration. At counter==ITER-1, next state is DONE.
- Timing: start accepted in cycle N → 32 iteration cycles N+1..N+32 → DONE from N+33. In the DONE cycle, done=1, hi/lo are valid and stallreq=0.
- Sign fix-up (registered on entry to DONE):
  - mult: negate the 64-bit product if sign_a^sign_b.
  - div: quotient negated if sign_a^sign_b; remainder takes the dividend's sign.
- div/divu with src_b==0: skip iteration, DONE at N+1, hi=src_a, lo=32'hFFFF_FFFF.
- Signed 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0 (natural wrap, no trap).
- DONE:
  - If stall_ex=1: remain in DONE, done=1, hi/lo held.
  - Else, with start=0: go to IDLE, done=0, hi/lo keep their last value.
  - Else, with start=1: accept the new op (back-to-back).
- start while busy: ignored; operands are not re-latched.
- cancel=1: next state IDLE, busy=0, done=0, hi/lo unchanged. If cancel and start occur in the same cycle, cancel wins.
- hi/lo change only on entry to DONE (or reset). They never expose partial values.

Optional Feature:
MULDIV_FAST_MUL_EN:
- Defined: mult/multu are computed by a single-cycle 64-bit combinational multiplier. Start in cycle N → DONE at N+1, and MUL is never entered. stallreq is high only in the issue cycle.
- Undefined: iterative 32-cycle multiply as described above. Division is unaffected in both cases.

Test Plan:
1. multu 0xFFFF_FFFF × 0xFFFF_FFFF → stallreq=1 for cycles N..N+32; done at N+33 with hi=0xFFFF_FFFE, lo=0x0000_0001. With MULDIV_FAST_MUL_EN, done at N+1.
2. mult 0xFFFF_FFFD (-3) × 5 → hi=0xFFFF_FFFF, lo=0xFFFF_FFF1. div -7/2 → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. divu 100/7 → lo=14, hi=2.
3. divu 100/0 → done at N+1, hi=100, lo=0xFFFF_FFFF. Signed 0x8000_0000/0xFFFF_FFFF → lo=0x8000_0000, hi=0.
4. Start div, assert cancel at iteration 10 → IDLE next cycle, done never pulses, hi/lo keep prior values. Repeat with rst=0 mid-op → all outputs 0 next cycle.
5. DONE with stall_ex=1 for 3 cycles → done and hi/lo stable for 3 cycles. Then start at the release cycle → new op accepted with no idle gap.
6. start pulsed during MUL with different operands → ignored; the original result is produced at N+33.
